// File: rtl/iter_shifter.sv
// Multi-cycle SLL/SRL/SRA/ROR unit: shifts at most STEP bits per clock,
// using a start/busy/done handshake so callers can stall on long shifts.
module iter_shifter #(
  parameter int WIDTH = 32,
  parameter int STEP  = 2,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] din,
  input  logic [SHW-1:0]   shamt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dout
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  localparam logic [1:0]     OP_SLL = 2'b00;
  localparam logic [1:0]     OP_SRL = 2'b01;
  localparam logic [1:0]     OP_SRA = 2'b10;
  localparam logic [SHW-1:0] STEP_K = SHW'(STEP);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] work, work_nxt, dout_nxt;
  logic [SHW-1:0]   rem, rem_nxt, k;
  logic [1:0]       op_q, op_nxt;

  // k is always >= 1 when called from SHIFT, so the ROR back-shift stays < WIDTH.
  // SRA keeps the operand sign because the MSB of work never changes under >>>.
  function automatic logic [WIDTH-1:0] shift_step(input logic [1:0] o,
                                                  input logic [WIDTH-1:0] w,
                                                  input logic [SHW-1:0] amt);
    case (o)
      OP_SLL:  shift_step = w << amt;
      OP_SRL:  shift_step = w >> amt;
      OP_SRA:  shift_step = WIDTH'($signed(w) >>> amt);
      default: shift_step = (w >> amt) | (w << (WIDTH - int'(amt)));
    endcase
  endfunction

  always_comb begin
    state_nxt = state;
    work_nxt  = work;
    rem_nxt   = rem;
    op_nxt    = op_q;
    dout_nxt  = dout;
    k         = '0;
    case (state)
      S_IDLE: begin
        if (start) begin
          work_nxt = din;
          op_nxt   = op;
          rem_nxt  = shamt;
          if (shamt == '0) begin
            state_nxt = S_DONE;
            dout_nxt  = din;
          end else begin
            state_nxt = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        k        = (rem > STEP_K) ? STEP_K : rem;
        work_nxt = shift_step(op_q, work, k);
        rem_nxt  = rem - k;
        if (rem_nxt == '0) begin
          state_nxt = S_DONE;
          dout_nxt  = work_nxt;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // dout is loaded on the edge entering DONE so it is valid alongside done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      work  <= '0;
      rem   <= '0;
      op_q  <= '0;
      dout  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      work  <= work_nxt;
      rem   <= rem_nxt;
      op_q  <= op_nxt;
      dout  <= dout_nxt;
      busy  <= (state_nxt != S_IDLE);
      done  <= (state_nxt == S_DONE);
    end
  end

endmodule

// File: tb/tb_iter_shifter.sv
// Scoreboard bench for iter_shifter: 32-bit/STEP=2 and 16-bit/STEP=4 instances,
// directed cases plus random ops against a bit-at-a-time reference model.
module tb_iter_shifter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        start0, busy0, done0;
  logic [1:0]  op0;
  logic [31:0] din0, dout0;
  logic [4:0]  shamt0;
  logic        start1, busy1, done1;
  logic [1:0]  op1;
  logic [15:0] din1, dout1;
  logic [3:0]  shamt1;

  iter_shifter #(.WIDTH(32), .STEP(2), .SHW(5)) dut32 (
    .clk(clk), .rst_n(rst_n), .start(start0), .op(op0), .din(din0), .shamt(shamt0),
    .busy(busy0), .done(done0), .dout(dout0));

  iter_shifter #(.WIDTH(16), .STEP(4), .SHW(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start1), .op(op1), .din(din1), .shamt(shamt1),
    .busy(busy1), .done(done1), .dout(dout1));

  typedef struct {
    logic [31:0] res;
    int          acc;
    int          n;
  } exp_t;

  exp_t        q0[$], q1[$];
  logic [31:0] last0, last1;
  int          cyc = 0;
  int          vectors = 0;
  int          errs = 0;

  always @(posedge clk) cyc++;

  task automatic check(string nm, logic [31:0] act, logic [31:0] want);
    vectors++;
    if (act !== want) begin
      errs++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  // Reference: apply the operation one bit position at a time.
  function automatic logic [31:0] model(int w, logic [1:0] o, logic [31:0] d, int s);
    logic [31:0] mask, r;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    r = d & mask;
    for (int i = 0; i < s; i++) begin
      case (o)
        2'b00:   r = (r << 1) & mask;
        2'b01:   r = r >> 1;
        2'b10:   r = (r >> 1) | (32'(r[w-1]) << (w - 1));
        default: r = (r >> 1) | (32'(r[0]) << (w - 1));
      endcase
    end
    return r;
  endfunction

  // Monitors: pop expectation on done, check value and latency; otherwise dout must hold.
  always @(negedge clk) begin
    exp_t e;
    if (done0) begin
      if (q0.size() == 0) check("spurious_done32", 32'd1, 32'd0);
      else begin
        e = q0.pop_front();
        check("dout32", dout0, e.res);
        check("latency32", 32'(cyc - e.acc), 32'(e.n));
        last0 = e.res;
      end
    end else check("hold32", dout0, last0);
  end

  always @(negedge clk) begin
    exp_t e;
    if (done1) begin
      if (q1.size() == 0) check("spurious_done16", 32'd1, 32'd0);
      else begin
        e = q1.pop_front();
        check("dout16", 32'(dout1), e.res);
        check("latency16", 32'(cyc - e.acc), 32'(e.n));
        last1 = e.res;
      end
    end else check("hold16", 32'(dout1), last1);
  end

  task automatic wait_idle(int sel);
    int n = 0;
    @(negedge clk);
    while (((sel == 0) ? busy0 : busy1) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic push_exp(int sel, logic [31:0] want, int s);
    exp_t e;
    e.res = want;
    e.acc = cyc;
    e.n   = (sel == 0) ? (s + 1) / 2 : (s + 3) / 4;
    if (sel == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  task automatic issue(int sel, logic [1:0] o, logic [31:0] d, int s, bit push,
                       logic [31:0] want);
    wait_idle(sel);
    if (sel == 0) begin
      op0 = o; din0 = d; shamt0 = 5'(s); start0 = 1'b1;
    end else begin
      op1 = o; din1 = d[15:0]; shamt1 = 4'(s); start1 = 1'b1;
    end
    @(posedge clk);
    #1;
    start0 = 1'b0;
    start1 = 1'b0;
    if (push) push_exp(sel, want, s);
    check("busy_after_accept", 32'((sel == 0) ? busy0 : busy1), 32'd1);
  endtask

  initial begin
    logic [1:0]  o;
    logic [31:0] d;
    int          s, n;
    last0 = '0; last1 = '0;
    rst_n = 1'b0;
    start0 = 0; op0 = 0; din0 = 0; shamt0 = 0;
    start1 = 0; op1 = 0; din1 = 0; shamt1 = 0;
    #2;
    check("reset_busy", 32'(busy0), 32'd0);
    check("reset_done", 32'(done0), 32'd0);
    check("reset_dout", dout0, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed 32-bit cases with independently stated results.
    issue(0, 2'b10, 32'h8000_0000, 2,  1, 32'hE000_0000);
    issue(0, 2'b01, 32'hF000_0000, 31, 1, 32'h0000_0001);
    issue(0, 2'b00, 32'h0000_0001, 31, 1, 32'h8000_0000);
    issue(0, 2'b11, 32'h1234_5678, 0,  1, 32'h1234_5678);
    issue(0, 2'b11, 32'h0000_0001, 1,  1, 32'h8000_0000);
    issue(0, 2'b10, 32'hFFFF_0000, 3,  1, 32'hFFFF_E000);

    // Start pulse during busy must be ignored.
    issue(0, 2'b00, 32'h0000_0001, 8, 1, 32'h0000_0100);
    @(negedge clk);
    op0 = 2'b11; din0 = 32'hAAAA_AAAA; shamt0 = 5'd3; start0 = 1'b1;
    @(posedge clk);
    #1 start0 = 1'b0;

    // Start held high: accepted, then accepted again in the IDLE cycle after DONE.
    wait_idle(0);
    op0 = 2'b01; din0 = 32'h0000_0100; shamt0 = 5'd4; start0 = 1'b1;
    @(posedge clk);
    #1 push_exp(0, 32'h0000_0010, 4);
    n = 0;
    @(negedge clk);
    while (busy0 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) check("hold_start_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1 push_exp(0, 32'h0000_0010, 4);
    start0 = 1'b0;
    check("busy_reaccept", 32'(busy0), 32'd1);

    // Asynchronous reset mid-shift abandons the operation.
    issue(0, 2'b10, 32'h8000_0000, 20, 0, 32'h0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    last0 = '0; last1 = '0;
    q0.delete(); q1.delete();
    #1;
    check("async_rst_busy", 32'(busy0), 32'd0);
    check("async_rst_done", 32'(done0), 32'd0);
    check("async_rst_dout", dout0, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    check("post_rst_busy", 32'(busy0), 32'd0);
    issue(0, 2'b01, 32'h0000_0100, 4, 1, 32'h0000_0010);

    // Random 32-bit traffic, occasionally poking start while busy.
    for (int i = 0; i < 60; i++) begin
      o = 2'($urandom);
      d = $urandom;
      s = $urandom_range(0, 31);
      issue(0, o, d, s, 1, model(32, o, d, s));
      if (s > 4 && $urandom_range(0, 2) == 0) begin
        @(negedge clk);
        din0 = $urandom; shamt0 = 5'($urandom); start0 = 1'b1;
        @(posedge clk);
        #1 start0 = 1'b0;
      end
    end

    // 16-bit, STEP=4 instance.
    issue(1, 2'b10, 32'h0000_8000, 15, 1, 32'h0000_FFFF);
    for (int i = 0; i < 30; i++) begin
      o = 2'($urandom);
      d = 32'($urandom_range(0, 16'hFFFF));
      s = $urandom_range(0, 15);
      issue(1, o, d, s, 1, model(16, o, d, s));
    end

    wait_idle(0);
    wait_idle(1);
    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(q0.size() + q1.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
